// File: rtl/clint_access_arbiter.sv
// clint_access_arbiter
//
// Shares the single CLINT AXI4 slave port between two register-access requesters
// (requester 0: core-side mailbox, requester 1: host/debug path). Requests are
// arbitrated round-robin. Each granted request becomes exactly one single-beat
// 64-bit AXI4 write (AW+W, then B) or read (AR, then R). The response goes back
// to the requester that was granted.
//
// Ports
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   reqN_valid_i / reqN_we_i        request pending / 1 = write
//   reqN_addr_i                     16-bit byte offset into the CLINT (bits [2:0] ignored)
//   reqN_wdata_i / reqN_be_i        write data / byte enables
//   reqN_gnt_o                      one-cycle grant (request fields are captured here)
//   reqN_rsp_valid_o                one-cycle response strobe
//   reqN_rsp_rdata_o / _err_o       read data (0 for writes) / error flag
//   aw_*, w_*, b_*, ar_*, r_*       AXI4 master channels to the CLINT wrapper
//
// The constant AXI fields (len, size, burst, id = AXI_ID, w_last, etc.) are
// driven by the integrating wrapper, so they are not ports here.

module clint_access_arbiter #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    // Requester 0
    input  logic        req0_valid_i,
    input  logic        req0_we_i,
    input  logic [15:0] req0_addr_i,
    input  logic [63:0] req0_wdata_i,
    input  logic [7:0]  req0_be_i,
    output logic        req0_gnt_o,
    output logic        req0_rsp_valid_o,
    output logic [63:0] req0_rsp_rdata_o,
    output logic        req0_rsp_err_o,

    // Requester 1
    input  logic        req1_valid_i,
    input  logic        req1_we_i,
    input  logic [15:0] req1_addr_i,
    input  logic [63:0] req1_wdata_i,
    input  logic [7:0]  req1_be_i,
    output logic        req1_gnt_o,
    output logic        req1_rsp_valid_o,
    output logic [63:0] req1_rsp_rdata_o,
    output logic        req1_rsp_err_o,

    // AXI4 write address / data / response
    output logic [63:0] aw_addr_o,
    output logic        aw_valid_o,
    input  logic        aw_ready_i,
    output logic [63:0] w_data_o,
    output logic [7:0]  w_strb_o,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    input  logic [1:0]  b_resp_i,
    input  logic        b_valid_i,
    output logic        b_ready_o,

    // AXI4 read address / data
    output logic [63:0] ar_addr_o,
    output logic        ar_valid_o,
    input  logic        ar_ready_i,
    input  logic [63:0] r_data_i,
    input  logic [1:0]  r_resp_i,
    input  logic        r_last_i,
    input  logic        r_valid_i,
    output logic        r_ready_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StBwait,
        StRd,
        StRwait,
        StRsp
    } state_e;

    state_e      state_q;
    logic        last_owner_q;  // round-robin pointer: owner of the last completed access
    logic        owner_q;       // requester that owns the current access
    logic [63:0] addr_q;        // absolute AXI address of the current access
    logic [63:0] wdata_q;
    logic [7:0]  be_q;
    logic        aw_valid_q;
    logic        w_valid_q;
    logic        ar_valid_q;
    logic        b_ready_q;
    logic        r_ready_q;
    logic        rsp_valid_q;
    logic [63:0] rdata_q;
    logic        err_q;

    // Arbitration
    logic        any_req;
    logic        winner;
    logic        grant;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [63:0] sel_wdata;
    logic [7:0]  sel_be;
    logic [63:0] sel_axi_addr;

    assign any_req = req0_valid_i | req1_valid_i;

    // When both requesters are valid, the one that did not own the last access wins.
    // A lone requester always wins.
    assign winner = (req0_valid_i & req1_valid_i) ? ~last_owner_q : req1_valid_i;

    // The grant is gated by rst_ni. This keeps the grant low while reset is held,
    // even though the FSM already sits in idle.
    assign grant = rst_ni & (state_q == StIdle) & any_req;

    assign req0_gnt_o = grant & ~winner;
    assign req1_gnt_o = grant & winner;

    assign sel_we    = winner ? req1_we_i    : req0_we_i;
    assign sel_addr  = winner ? req1_addr_i  : req0_addr_i;
    assign sel_wdata = winner ? req1_wdata_i : req0_wdata_i;
    assign sel_be    = winner ? req1_be_i    : req0_be_i;

    // 64-bit add; it wraps modulo 2^64 by construction.
    assign sel_axi_addr = BASE_ADDR + {48'b0, sel_addr[15:3], 3'b000};

    // Sub-word offset bits and the AXI ID are intentionally not consumed here.
    logic unused_bits;
    assign unused_bits = ^{req0_addr_i[2:0], req1_addr_i[2:0], AXI_ID};

    // Control FSM and all registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            ar_valid_q   <= 1'b0;
            b_ready_q    <= 1'b0;
            r_ready_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        owner_q <= winner;
                        addr_q  <= sel_axi_addr;
                        wdata_q <= sel_wdata;
                        be_q    <= sel_be;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        if (sel_we) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            state_q    <= StWr;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= StRd;
                        end
                    end
                end

                StWr: begin
                    // AW and W complete independently. Leave once both are done,
                    // which may happen in the same cycle.
                    if (aw_valid_q && aw_ready_i) begin
                        aw_valid_q <= 1'b0;
                    end
                    if (w_valid_q && w_ready_i) begin
                        w_valid_q <= 1'b0;
                    end
                    if ((!aw_valid_q || aw_ready_i) && (!w_valid_q || w_ready_i)) begin
                        b_ready_q <= 1'b1;
                        state_q   <= StBwait;
                    end
                end

                StBwait: begin
                    if (b_valid_i) begin
                        b_ready_q   <= 1'b0;
                        err_q       <= (b_resp_i != 2'b00);
                        rdata_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StRsp;
                    end
                end

                StRd: begin
                    if (ar_ready_i) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= StRwait;
                    end
                end

                StRwait: begin
                    if (r_valid_i) begin
                        r_ready_q   <= 1'b0;
                        rdata_q     <= r_data_i;
                        // A single-beat read that is not marked last is treated as an error.
                        err_q       <= (r_resp_i != 2'b00) | ~r_last_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StRsp;
                    end
                end

                StRsp: begin
                    rsp_valid_q  <= 1'b0;
                    last_owner_q <= owner_q;
                    state_q      <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output assignments
    assign aw_addr_o  = addr_q;
    assign aw_valid_o = aw_valid_q;
    assign w_data_o   = wdata_q;
    assign w_strb_o   = be_q;
    assign w_valid_o  = w_valid_q;
    assign b_ready_o  = b_ready_q;
    assign ar_addr_o  = addr_q;
    assign ar_valid_o = ar_valid_q;
    assign r_ready_o  = r_ready_q;

    // Only the owner sees the response. The non-owner's outputs are held at zero.
    assign req0_rsp_valid_o = rsp_valid_q & ~owner_q;
    assign req0_rsp_rdata_o = owner_q ? 64'd0 : rdata_q;
    assign req0_rsp_err_o   = ~owner_q & err_q;

    assign req1_rsp_valid_o = rsp_valid_q & owner_q;
    assign req1_rsp_rdata_o = owner_q ? rdata_q : 64'd0;
    assign req1_rsp_err_o   = owner_q & err_q;

endmodule

// File: tb/tb_clint_access_arbiter.sv
// Self-checking bench for clint_access_arbiter. The bench plays both requesters and a
// configurable-latency AXI slave. A small reference model predicts the round-robin
// winner, the AXI address and the response.

module tb_clint_access_arbiter;

    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [1:0]  rq_valid;
    logic [1:0]  rq_we;
    logic [15:0] rq_addr  [2];
    logic [63:0] rq_wdata [2];
    logic [7:0]  rq_be    [2];

    logic        req0_gnt, req1_gnt, req0_rsp_valid, req1_rsp_valid, req0_rsp_err, req1_rsp_err;
    logic [63:0] req0_rsp_rdata, req1_rsp_rdata;

    logic [63:0] aw_addr, w_data, ar_addr, r_data;
    logic [7:0]  w_strb;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [1:0]  b_resp, r_resp;

    logic [1:0]  gnt, rsp_v, rsp_err;
    logic [63:0] rsp_rdata [2];
    assign gnt          = {req1_gnt, req0_gnt};
    assign rsp_v        = {req1_rsp_valid, req0_rsp_valid};
    assign rsp_err      = {req1_rsp_err, req0_rsp_err};
    assign rsp_rdata[0] = req0_rsp_rdata;
    assign rsp_rdata[1] = req1_rsp_rdata;

    clint_access_arbiter #(
        .BASE_ADDR (BASE),
        .AXI_ID    (4'd0)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req0_valid_i     (rq_valid[0]),
        .req0_we_i        (rq_we[0]),
        .req0_addr_i      (rq_addr[0]),
        .req0_wdata_i     (rq_wdata[0]),
        .req0_be_i        (rq_be[0]),
        .req0_gnt_o       (req0_gnt),
        .req0_rsp_valid_o (req0_rsp_valid),
        .req0_rsp_rdata_o (req0_rsp_rdata),
        .req0_rsp_err_o   (req0_rsp_err),
        .req1_valid_i     (rq_valid[1]),
        .req1_we_i        (rq_we[1]),
        .req1_addr_i      (rq_addr[1]),
        .req1_wdata_i     (rq_wdata[1]),
        .req1_be_i        (rq_be[1]),
        .req1_gnt_o       (req1_gnt),
        .req1_rsp_valid_o (req1_rsp_valid),
        .req1_rsp_rdata_o (req1_rsp_rdata),
        .req1_rsp_err_o   (req1_rsp_err),
        .aw_addr_o        (aw_addr),
        .aw_valid_o       (aw_valid),
        .aw_ready_i       (aw_ready),
        .w_data_o         (w_data),
        .w_strb_o         (w_strb),
        .w_valid_o        (w_valid),
        .w_ready_i        (w_ready),
        .b_resp_i         (b_resp),
        .b_valid_i        (b_valid),
        .b_ready_o        (b_ready),
        .ar_addr_o        (ar_addr),
        .ar_valid_o       (ar_valid),
        .ar_ready_i       (ar_ready),
        .r_data_i         (r_data),
        .r_resp_i         (r_resp),
        .r_last_i         (r_last),
        .r_valid_i        (r_valid),
        .r_ready_o        (r_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Slave behaviour for the next transaction
    int          aw_dly, w_dly, ar_dly, rsp_dly;
    logic [1:0]  s_resp;
    logic        s_last;
    logic [63:0] s_rdata;

    // Reference model: owner of the last completed access (1 after reset)
    int last_owner = 1;

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b11) return (last_owner == 0) ? 1 : 0;
        return v[1] ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // Runs one complete access. Call at posedge+1 with the DUT idle and rq_* already set.
    task automatic run_txn(output int won);
        int          w, k, t0;
        bit          a_done, d_done, done, zero;
        logic [63:0] exp_addr, exp_rdata;
        logic        exp_err;
        w        = pick(rq_valid);
        won      = w;
        exp_addr = BASE + {48'b0, rq_addr[w][15:3], 3'b000};
        @(negedge clk);
        chk("gnt_win", gnt[w], 1'b1);
        chk("gnt_other", gnt[1-w], 1'b0);
        chk("rsp_idle", rsp_v, 2'b00);
        t0 = cyc;
        @(posedge clk); #1;
        rq_valid[w] = 1'b0;
        if (rq_we[w]) begin
            zero   = (aw_dly == 0) && (w_dly == 0) && (rsp_dly == 0);
            a_done = 0; d_done = 0; k = 0;
            while (!(a_done && d_done) && k < 50) begin
                k++;
                aw_ready = !a_done && (k > aw_dly);
                w_ready  = !d_done && (k > w_dly);
                @(negedge clk);
                chk("gnt_busy", gnt, 2'b00);
                chk("b_ready_early", b_ready, 1'b0);
                if (!a_done) begin
                    chk("aw_valid", aw_valid, 1'b1);
                    chk("aw_addr", aw_addr, exp_addr);
                    a_done = aw_ready;
                end else chk("aw_dropped", aw_valid, 1'b0);
                if (!d_done) begin
                    chk("w_valid", w_valid, 1'b1);
                    chk("w_data", w_data, rq_wdata[w]);
                    chk("w_strb", w_strb, rq_be[w]);
                    d_done = w_ready;
                end else chk("w_dropped", w_valid, 1'b0);
                @(posedge clk); #1;
            end
            aw_ready = 0; w_ready = 0;
            chk("aw_w_timeout", a_done && d_done, 1'b1);
            done = 0; k = 0;
            while (!done && k < 50) begin
                k++;
                b_valid = (k > rsp_dly);
                b_resp  = s_resp;
                @(negedge clk);
                chk("b_ready", b_ready, 1'b1);
                chk("aw_w_idle", {aw_valid, w_valid}, 2'b00);
                done = b_valid;
                @(posedge clk); #1;
            end
            b_valid = 0;
            chk("b_timeout", done, 1'b1);
            exp_rdata = 64'd0;
            exp_err   = (s_resp != 2'b00);
        end else begin
            zero = (ar_dly == 0) && (rsp_dly == 0);
            done = 0; k = 0;
            while (!done && k < 50) begin
                k++;
                ar_ready = (k > ar_dly);
                @(negedge clk);
                chk("gnt_busy", gnt, 2'b00);
                chk("r_ready_early", r_ready, 1'b0);
                chk("ar_valid", ar_valid, 1'b1);
                chk("ar_addr", ar_addr, exp_addr);
                done = ar_ready;
                @(posedge clk); #1;
            end
            ar_ready = 0;
            chk("ar_timeout", done, 1'b1);
            done = 0; k = 0;
            while (!done && k < 50) begin
                k++;
                r_valid = (k > rsp_dly);
                r_data  = s_rdata;
                r_resp  = s_resp;
                r_last  = s_last;
                @(negedge clk);
                chk("r_ready", r_ready, 1'b1);
                chk("ar_idle", ar_valid, 1'b0);
                done = r_valid;
                @(posedge clk); #1;
            end
            r_valid = 0;
            chk("r_timeout", done, 1'b1);
            exp_rdata = s_rdata;
            exp_err   = (s_resp != 2'b00) || !s_last;
        end
        @(negedge clk);
        chk("rsp_valid", rsp_v[w], 1'b1);
        chk("rsp_other", rsp_v[1-w], 1'b0);
        chk("rsp_rdata", rsp_rdata[w], exp_rdata);
        chk("rsp_err", rsp_err[w], exp_err);
        chk("gnt_rsp", gnt, 2'b00);
        chk("readies_rsp", {b_ready, r_ready}, 2'b00);
        if (zero) chk("latency", cyc - t0, 3);
        last_owner = w;
        @(posedge clk); #1;
    endtask

    initial begin
        int won;
        rst_n    = 1'b0;
        rq_valid = 2'b11;  // requests present during reset must not be granted
        rq_we    = 2'b00;
        for (int j = 0; j < 2; j++) begin
            rq_addr[j] = '0; rq_wdata[j] = '0; rq_be[j] = '0;
        end
        aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
        ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0; r_last = 1;
        aw_dly = 0; w_dly = 0; ar_dly = 0; rsp_dly = 0;
        s_resp = 0; s_last = 1; s_rdata = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rsp_valid", rsp_v, 2'b00);
        chk("rst_valids", {aw_valid, w_valid, ar_valid}, 3'b000);
        chk("rst_readies", {b_ready, r_ready}, 2'b00);
        chk("rst_rdata", rsp_rdata[0] | rsp_rdata[1], 64'd0);
        chk("rst_err", rsp_err, 2'b00);
        rq_valid = 2'b00;
        rst_n    = 1'b1;
        @(posedge clk); #1;

        // Zero-wait write from requester 0
        rq_valid = 2'b01; rq_we[0] = 1; rq_addr[0] = 16'h4000;
        rq_wdata[0] = 64'h1234; rq_be[0] = 8'hFF;
        run_txn(won);
        chk("t1_aw_addr_abs", BASE + 64'h4000, 64'h0000_0000_0200_4000);

        // Read of mtime from requester 1
        rq_valid = 2'b10; rq_we[1] = 0; rq_addr[1] = 16'hBFF8;
        s_rdata = 64'hDEAD_BEEF; s_resp = 0; s_last = 1;
        run_txn(won);

        // Both requesting continuously: grants must alternate 0,1,0,1,...
        for (int i = 0; i < 8; i++) begin
            rq_valid = 2'b11;
            for (int j = 0; j < 2; j++) begin
                rq_we[j]    = 1'($urandom);
                rq_addr[j]  = 16'($urandom);
                rq_wdata[j] = {$urandom, $urandom};
                rq_be[j]    = 8'($urandom);
            end
            aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2);
            ar_dly = $urandom_range(0, 2); rsp_dly = $urandom_range(0, 2);
            s_resp = 0; s_last = 1; s_rdata = {$urandom, $urandom};
            run_txn(won);
            chk("alternate", won, i % 2);
        end

        // AW ready three cycles late, W ready immediately
        rq_valid = 2'b01; rq_we[0] = 1; rq_addr[0] = 16'h0008;
        rq_wdata[0] = 64'hA5A5_0000_1111_2222; rq_be[0] = 8'h0F;
        aw_dly = 3; w_dly = 0; ar_dly = 0; rsp_dly = 0; s_resp = 0;
        run_txn(won);

        // SLVERR on B, then OKAY read without r_last
        rq_valid = 2'b10; rq_we[1] = 1; rq_addr[1] = 16'h0010; aw_dly = 0;
        s_resp = 2'b10;
        run_txn(won);
        rq_valid = 2'b01; rq_we[0] = 0; rq_addr[0] = 16'hBFF8;
        s_resp = 2'b00; s_last = 0; s_rdata = 64'h0123_4567_89AB_CDEF;
        run_txn(won);
        s_last = 1;

        // Request withdrawn before any clock edge sees it: nothing is issued
        rq_valid = 2'b01; rq_we[0] = 1;
        #2 rq_valid = 2'b00;
        @(negedge clk);
        chk("withdraw_gnt", gnt, 2'b00);
        @(negedge clk);
        chk("withdraw_idle", {aw_valid, w_valid, ar_valid}, 3'b000);
        @(posedge clk); #1;

        // Reset asserted while waiting for R
        rq_valid = 2'b10; rq_we[1] = 0; rq_addr[1] = 16'hBFF8;
        @(negedge clk);
        chk("rstx_gnt", gnt, 2'b10);
        @(posedge clk); #1;
        rq_valid = 2'b00; ar_ready = 1;
        @(negedge clk);
        chk("rstx_ar_valid", ar_valid, 1'b1);
        @(posedge clk); #1;
        ar_ready = 0;
        @(negedge clk);
        chk("rstx_r_ready", r_ready, 1'b1);
        rq_valid = 2'b11; r_valid = 1; r_data = 64'hFFFF; r_resp = 0; r_last = 1;
        rst_n = 1'b0;
        #1;
        chk("rstx_valids", {aw_valid, w_valid, ar_valid}, 3'b000);
        chk("rstx_readies", {b_ready, r_ready}, 2'b00);
        chk("rstx_gnt_low", gnt, 2'b00);
        chk("rstx_rsp", rsp_v, 2'b00);
        @(posedge clk); #1;
        r_valid = 0; rq_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        last_owner = 1;
        @(negedge clk);
        chk("rstx_no_rsp", rsp_v, 2'b00);
        @(posedge clk); #1;
        rq_valid = 2'b11; rq_we = 2'b01; rq_addr[0] = 16'h0000; rq_addr[1] = 16'h0008;
        aw_dly = 0; w_dly = 0; rsp_dly = 0; s_resp = 0;
        run_txn(won);
        chk("rstx_first_winner", won, 0);

        // Randomized mix of requesters, directions, latencies and responses
        for (int i = 0; i < 30; i++) begin
            rq_valid = 2'($urandom_range(1, 3));
            for (int j = 0; j < 2; j++) begin
                rq_we[j]    = 1'($urandom);
                rq_addr[j]  = 16'($urandom);
                rq_wdata[j] = {$urandom, $urandom};
                rq_be[j]    = 8'($urandom);
            end
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); rsp_dly = $urandom_range(0, 3);
            s_resp  = 2'($urandom_range(0, 3));
            s_last  = ($urandom_range(0, 3) != 0);
            s_rdata = {$urandom, $urandom};
            run_txn(won);
        end

        rq_valid = 2'b00;
        @(negedge clk);
        chk("final_rsp_low", rsp_v, 2'b00);
        chk("final_idle", {aw_valid, w_valid, ar_valid, b_ready, r_ready}, 5'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clint_access_arbiter.md
# clint_access_arbiter

Shares the single CLINT AXI4 slave port between two simple register-access requesters (requester 0: Ara/Ariane core-side mailbox; requester 1: host/debug path). It arbitrates round-robin, converts each granted request into exactly one single-beat 64-bit AXI4 read or write, and returns the response to the granted requester. It sits between the requesters and the CLINT wrapper; the CLINT timer and IPI outputs are unaffected.

## Interface
Parameters:
- BASE_ADDR, 64'h0000_0000_0200_0000, CLINT base; added to requester offset
- AXI_ID, 4'd0, ID driven on AW/AR; B/R IDs ignored

Ports (N = 0,1; one set per requester):
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- reqN_valid_i  in  1  request pending; held until reqN_gnt_o
- reqN_we_i  in  1  1 = write, 0 = read
- reqN_addr_i  in  16  byte offset into CLINT; bits [2:0] ignored
- reqN_wdata_i  in  64  write data
- reqN_be_i  in  8  byte enables → w_strb
- reqN_gnt_o  out  1  one-cycle grant; request fields captured this cycle
- reqN_rsp_valid_o  out  1  one-cycle response strobe
- reqN_rsp_rdata_o  out  64  read data (0 for writes)
- reqN_rsp_err_o  out  1  response error
- aw_addr_o / aw_valid_o / aw_ready_i  64/1/1  AW channel
- w_data_o / w_strb_o / w_valid_o / w_ready_i  64/8/1/1  W channel
- b_resp_i / b_valid_i / b_ready_o  2/1/1  B channel
- ar_addr_o / ar_valid_o / ar_ready_i  64/1/1  AR channel
- r_data_i / r_resp_i / r_last_i / r_valid_i / r_ready_o  64/2/1/1/1  R channel
- Constant AXI fields (driven by the integrating wrapper from this block): len 0, size 3'd3, burst INCR, id AXI_ID, lock/cache/prot/qos/region/user/atop 0; w_last = 1.

## Operation
- FSM: IDLE, WR (AW+W outstanding), BWAIT, RD (AR outstanding), RWAIT, RSP.
- IDLE: if any reqN_valid_i, choose winner; assert its gnt combinationally; capture we/addr/wdata/be and owner; go WR (we=1) or RD (we=0).
- Round-robin: pointer holds last owner; reset value 1, so requester 0 wins first contention. When both valid, the non-last owner wins; a lone requester always wins.
- Address: axi addr = BASE_ADDR + {48'b0, addr[15:3], 3'b000} (64-bit add, wrap modulo 2^64).
- WR: aw_valid and w_valid both asserted; each dropped independently after its handshake; go BWAIT once both done (may be same cycle).
- BWAIT: b_ready = 1; on b_valid capture err = (b_resp != 2'b00); go RSP.
- RD: ar_valid until ar_ready; go RWAIT. RWAIT: r_ready = 1; on r_valid capture r_data and err = (r_resp != 2'b00) | ~r_last_i; go RSP.
- RSP: owner's rsp_valid = 1 with captured rdata/err, for one cycle; update pointer; go IDLE.
- Non-owner's rsp_valid, gnt always 0. rdata is 0 for writes.
- AXI valids never drop before handshake; address/data stable while valid.

## Timing
- Reset (async): state IDLE, pointer = 1, all gnt/rsp_valid/aw/w/ar valids and b_ready/r_ready 0, rdata 0, err 0, captured regs 0.
- Reset mid-transaction: all outputs return to reset values immediately; in-flight response is dropped, requester gets no rsp_valid.
- Write, zero-wait slave: cycle 0 gnt; cycle 1 aw/w valid+ready; cycle 2 b_valid; cycle 3 rsp_valid; cycle 4 next gnt possible. Read identical with AR/R.
- Exactly one outstanding transaction; no gnt outside IDLE.
- b_valid/r_valid arriving in WR/RD (before address phase done) is not accepted (ready low).
- Requester deasserting valid before gnt: allowed; no transaction issued.

## Test plan
- Write req0 addr 16'h4000 wdata 64'h1234 be 8'hFF → aw_addr 64'h0200_4000, w_data 64'h1234, strb FF; B OKAY → req0 rsp_valid one cycle, err 0, total 4 cycles.
- Read req1 addr 16'hBFF8 (mtime), R data 64'hDEAD_BEEF OKAY last=1 → ar_addr 64'h0200_BFF8, req1 rdata 64'hDEAD_BEEF, err 0.
- Both requesting continuously after reset → grants alternate 0,1,0,1; no starvation over 8 transactions.
- AW ready 3 cycles late, W ready immediate → w_valid drops after cycle 1, aw_valid held stable until ready, single B accepted.
- B resp SLVERR, then R OKAY with r_last=0 → rsp_err 1 in both cases.
- rst_ni low during RWAIT → all valids/readies 0 same cycle; after release req0 wins first grant.
